// File: rtl/wait_timer.sv
// Programmable one-shot delay timer. A start request loads a tick count; the
// timer counts clock edges down and emits a single-cycle out pulse on expiry.
module wait_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tick,
    output logic             out,
    output logic             busy,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic [0:0] {
        StIdle,
        StCount
    } state_e;

    localparam logic [WIDTH-1:0] CntZero = '0;
    localparam logic [WIDTH-1:0] CntOne  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic [WIDTH-1:0] load_val;

    // A zero-length request still produces a pulse, one edge later.
    assign load_val = (tick == CntZero) ? CntOne : tick;

    // Next-state: a load beats everything, including a same-edge expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = 1'b0;
        if (start) begin
            state_d = StCount;
            cnt_d   = load_val;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = CntZero;
                end
                StCount: begin
                    if (cnt_q == CntOne) begin
                        out_d   = 1'b1;
                        state_d = StIdle;
                        cnt_d   = CntZero;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = CntZero;
                end
            endcase
        end
    end

    // State register; reset discards any pending count immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= CntZero;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out       = out_q;
    assign busy      = (state_q == StCount);
    assign remaining = cnt_q;

`ifndef SYNTHESIS
    // The counter is nonzero exactly while a count is running.
    a_busy_matches_cnt: assert property (@(posedge clk) disable iff (reset)
        busy == (remaining != CntZero));
    // The timeout pulse only ever appears once the timer has gone idle.
    a_out_implies_idle: assert property (@(posedge clk) disable iff (reset)
        out |-> !busy);
    // out is a pulse: it cannot stay high for two consecutive cycles.
    a_out_is_pulse: assert property (@(posedge clk) disable iff (reset)
        out |=> !out);
`endif

endmodule

// File: tb/tb_wait_timer.sv
// Directed bench for wait_timer with hand-computed expected values.
module tb_wait_timer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] tick;
    logic             out;
    logic             busy;
    logic [WIDTH-1:0] remaining;

    int n_cmp;
    int n_bad;

    wait_timer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tick      (tick),
        .out       (out),
        .busy      (busy),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start request; returns 1ns after the sampling edge.
    task automatic pulse_start(input int t);
        start = 1'b1;
        tick  = t[WIDTH-1:0];
        step();
        start = 1'b0;
    endtask

    // Watch n edges; count out pulses and note the edge index of the first.
    task automatic watch(input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= n; i++) begin
            step();
            if (out === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    initial begin
        int p;
        int f;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0;
        tick  = '0;
        step();
        step();
        reset = 1'b0;
        step();
        check("reset_out", out, 0);
        check("reset_busy", busy, 0);
        check("reset_rem", remaining, 0);

        // tick=3: 3,2,1 then a single pulse with busy low
        pulse_start(3);
        check("t3_rem_e0", remaining, 3);
        check("t3_busy_e0", busy, 1);
        check("t3_out_e0", out, 0);
        step();
        check("t3_rem_e1", remaining, 2);
        step();
        check("t3_rem_e2", remaining, 1);
        check("t3_out_e2", out, 0);
        step();
        check("t3_out_e3", out, 1);
        check("t3_busy_e3", busy, 0);
        check("t3_rem_e3", remaining, 0);
        step();
        check("t3_out_e4", out, 0);

        // tick=0 behaves like tick=1
        pulse_start(0);
        check("t0_rem", remaining, 1);
        check("t0_busy", busy, 1);
        watch(4, p, f);
        check("t0_first", f, 1);
        check("t0_pulses", p, 1);

        // tick=15: maximum delay
        pulse_start(15);
        watch(20, p, f);
        check("t15_first", f, 15);
        check("t15_pulses", p, 1);

        // restart while busy: tick=5, then tick=2 two edges later
        pulse_start(5);
        watch(1, p, f);
        check("rst5_early", p, 0);
        pulse_start(2);
        check("rst5_reload", remaining, 2);
        watch(8, p, f);
        check("rst5_first", f, 2);
        check("rst5_pulses", p, 1);

        // start on the expiry edge: restart wins
        pulse_start(3);
        watch(2, p, f);
        check("exp_pre_rem", remaining, 1);
        pulse_start(3);
        check("exp_edge_out", out, 0);
        check("exp_edge_rem", remaining, 3);
        watch(6, p, f);
        check("exp_first", f, 3);
        check("exp_pulses", p, 1);

        // start held 3 edges, tick changed while busy
        start = 1'b1;
        tick  = 4'd4;
        step();
        step();
        step();
        start = 1'b0;
        tick  = 4'd9;
        check("hold_rem", remaining, 4);
        watch(10, p, f);
        check("hold_first", f, 4);
        check("hold_pulses", p, 1);

        // async reset while out is high clears it before the next edge
        pulse_start(1);
        step();
        check("ar_out_pre", out, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_out", out, 0);
        #2 reset = 1'b0;

        // reset mid-count: no pulse ever, busy stays low
        pulse_start(6);
        watch(2, p, f);
        #2 reset = 1'b1;
        #1;
        check("mid_out", out, 0);
        check("mid_busy", busy, 0);
        check("mid_rem", remaining, 0);
        #2 reset = 1'b0;
        watch(10, p, f);
        check("mid_pulses", p, 0);
        check("mid_busy_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
